// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA front end: 640x480@60 timing,
// sync polarity, pixel-bus width and the control bundle that rides the alignment pipe.
package vga_timing_pkg;

    localparam int VGA_CNTR_WIDTH_H = 11;
    localparam int VGA_CNTR_WIDTH_V = 10;

    localparam int VGA_R_WIDTH   = 8;
    localparam int VGA_G_WIDTH   = 8;
    localparam int VGA_B_WIDTH   = 8;
    localparam int VGA_PIX_WIDTH = VGA_R_WIDTH + VGA_G_WIDTH + VGA_B_WIDTH;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit VGA_SYNC_POL    = 1'b0;
    localparam int VGA_PIX_LATENCY = 2;

    // Raw control decoded from the counters; all fields active-high.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_ctrl_t;

    function automatic logic sync_level(input logic asserted, input bit pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Raster/pixel bundle between the timing generator, the pixel controller and the DAC pins.
interface vga_timing_generator_if
    import vga_timing_pkg::*;
#(
    parameter int CNTR_WIDTH_H = VGA_CNTR_WIDTH_H,
    parameter int CNTR_WIDTH_V = VGA_CNTR_WIDTH_V,
    parameter int R_WIDTH      = VGA_R_WIDTH,
    parameter int G_WIDTH      = VGA_G_WIDTH,
    parameter int B_WIDTH      = VGA_B_WIDTH
);
    logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] PixBus;
    logic [CNTR_WIDTH_H-1:0]            CounterX;
    logic [CNTR_WIDTH_V-1:0]            CounterY;
    logic [R_WIDTH-1:0]                 VGA_R;
    logic [G_WIDTH-1:0]                 VGA_G;
    logic [B_WIDTH-1:0]                 VGA_B;
    logic                               VGA_HS;
    logic                               VGA_VS;
    logic                               VGA_BLANK_N;
    logic                               VGA_SYNC_N;
    logic                               FrameStart;

    modport master (
        input  PixBus,
        output CounterX, CounterY, VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, FrameStart
    );

    modport slave (
        output PixBus,
        input  CounterX, CounterY, VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, FrameStart
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async active-low clear; DEPTH=0 collapses to a wire.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    if (DEPTH == 0) begin : g_bypass
        assign dout_o = din_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        // NOTE: every stage is cleared, not only the last one, so a reset mid-line
        // cannot replay stale sync/active bits to the pins after release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= din_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout_o = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_generator.sv
// Raster counters plus sync/blank generation, aligned with the returning pixel bus
// so the DAC pins show counter value N exactly PIX_LATENCY+1 clocks later.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int CNTR_WIDTH_H = VGA_CNTR_WIDTH_H,
    parameter int CNTR_WIDTH_V = VGA_CNTR_WIDTH_V,
    parameter int R_WIDTH      = VGA_R_WIDTH,
    parameter int G_WIDTH      = VGA_G_WIDTH,
    parameter int B_WIDTH      = VGA_B_WIDTH,
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_FP         = VGA_H_FP,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BP         = VGA_H_BP,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_FP         = VGA_V_FP,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BP         = VGA_V_BP,
    parameter bit SYNC_POL     = VGA_SYNC_POL,
    parameter int PIX_LATENCY  = VGA_PIX_LATENCY
) (
    input  logic                   CLOCK,
    input  logic                   RESET_N,
    vga_timing_generator_if.master vga
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIX_WIDTH = R_WIDTH + G_WIDTH + B_WIDTH;

    localparam logic [CNTR_WIDTH_H-1:0] X_LAST     = CNTR_WIDTH_H'(H_TOTAL - 1);
    localparam logic [CNTR_WIDTH_H-1:0] X_ACT_END  = CNTR_WIDTH_H'(H_ACTIVE);
    localparam logic [CNTR_WIDTH_H-1:0] HS_FIRST   = CNTR_WIDTH_H'(H_ACTIVE + H_FP);
    localparam logic [CNTR_WIDTH_H-1:0] HS_LAST    = CNTR_WIDTH_H'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNTR_WIDTH_V-1:0] Y_LAST     = CNTR_WIDTH_V'(V_TOTAL - 1);
    localparam logic [CNTR_WIDTH_V-1:0] Y_ACT_END  = CNTR_WIDTH_V'(V_ACTIVE);
    localparam logic [CNTR_WIDTH_V-1:0] VS_FIRST   = CNTR_WIDTH_V'(V_ACTIVE + V_FP);
    localparam logic [CNTR_WIDTH_V-1:0] VS_LAST    = CNTR_WIDTH_V'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNTR_WIDTH_H-1:0] cnt_x_q, cnt_x_d;
    logic [CNTR_WIDTH_V-1:0] cnt_y_q, cnt_y_d;
    vga_ctrl_t               ctrl_raw;
    vga_ctrl_t               ctrl_dly;
    logic                    blank_n_q;
    logic                    hs_q;
    logic                    vs_q;
    logic                    frame_start_q;
    logic [PIX_WIDTH-1:0]    pix_q;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_x_d = cnt_x_q + CNTR_WIDTH_H'(1);
        cnt_y_d = cnt_y_q;
        if (cnt_x_q == X_LAST) begin
            cnt_x_d = '0;
            cnt_y_d = (cnt_y_q == Y_LAST) ? '0 : cnt_y_q + CNTR_WIDTH_V'(1);
        end
    end

    always_comb begin
        ctrl_raw.active = (cnt_x_q < X_ACT_END) && (cnt_y_q < Y_ACT_END);
        ctrl_raw.hs     = (cnt_x_q >= HS_FIRST) && (cnt_x_q <= HS_LAST);
        ctrl_raw.vs     = (cnt_y_q >= VS_FIRST) && (cnt_y_q <= VS_LAST);
    end

    vga_delay_line #(
        .DEPTH (PIX_LATENCY),
        .WIDTH ($bits(vga_ctrl_t))
    ) u_ctrl_dly (
        .clk    (CLOCK),
        .rst_n  (RESET_N),
        .din_i  (ctrl_raw),
        .dout_o (ctrl_dly)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_x_q       <= '0;
            cnt_y_q       <= '0;
            blank_n_q     <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            pix_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_x_q       <= cnt_x_d;
            cnt_y_q       <= cnt_y_d;
            blank_n_q     <= ctrl_dly.active;
            hs_q          <= sync_level(ctrl_dly.hs, SYNC_POL);
            vs_q          <= sync_level(ctrl_dly.vs, SYNC_POL);
            pix_q         <= ctrl_dly.active ? vga.PixBus : '0;
            frame_start_q <= (cnt_x_q == '0) && (cnt_y_q == '0);
        end
    end

    // PixBus is packed {B G R} with R in the least significant bits.
    assign vga.CounterX    = cnt_x_q;
    assign vga.CounterY    = cnt_y_q;
    assign vga.VGA_R       = pix_q[R_WIDTH-1:0];
    assign vga.VGA_G       = pix_q[R_WIDTH +: G_WIDTH];
    assign vga.VGA_B       = pix_q[R_WIDTH+G_WIDTH +: B_WIDTH];
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.FrameStart  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator: full 800-clock lines, a 10-line frame
// (8000 clocks) so two frames plus a mid-frame reset stay short.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    localparam int V_ACT = 4;
    localparam int V_FPR = 2;
    localparam int V_SYN = 2;
    localparam int V_BPR = 2;
    localparam int V_TOT = 10;
    localparam int LAT   = 2;

    typedef struct packed {
        logic [10:0] cx;
        logic [9:0]  cy;
        logic        fs;
        logic        blank_n;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic [10:0] x;
        logic [9:0]  y;
    } coord_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_timing_generator_if vga ();

    vga_timing_generator #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FPR),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BPR)
    ) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .vga     (vga)
    );

    always #5 clk = ~clk;

    exp_t   sb_q[$];
    coord_t hist_q[$];
    int     mx, my;
    bit     running = 1'b0;
    bit     meas_en = 1'b1;
    int     mode    = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_restart();
        exp_t e0;
        sb_q.delete();
        hist_q.delete();
        for (int i = 0; i < LAT; i++) hist_q.push_back('0);
        mx = 0;
        my = 0;
        e0 = '{cx: 11'd0, cy: 10'd0, fs: 1'b0, blank_n: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'h0};
        sb_q.push_back(e0);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_cx"},      vga.CounterX,    0);
        check({tag, "_cy"},      vga.CounterY,    0);
        check({tag, "_hs"},      vga.VGA_HS,      1);
        check({tag, "_vs"},      vga.VGA_VS,      1);
        check({tag, "_blank_n"}, vga.VGA_BLANK_N, 0);
        check({tag, "_rgb"},     {vga.VGA_B, vga.VGA_G, vga.VGA_R}, 0);
        check({tag, "_fs"},      vga.FrameStart,  0);
    endtask

    // Stimulus: drive PixBus for the pixel shown LAT clocks ago and push the pins
    // expected one clock from now.
    coord_t      drv_d;
    exp_t        drv_e;
    logic [23:0] drv_pix;
    int          drv_nx, drv_ny;
    logic        drv_act;
    initial forever begin
        @(negedge clk);
        if (running) begin
            hist_q.push_back('{valid: 1'b1, x: 11'(mx), y: 10'(my)});
            drv_d = hist_q.pop_front();
            drv_pix = (mode == 0) ? {drv_d.x[7:0], 8'h55, 8'hAA} : 24'hFFFFFF;
            vga.PixBus = drv_pix;
            drv_act = drv_d.valid && (drv_d.x < 640) && (drv_d.y < V_ACT);
            drv_nx = (mx == 799) ? 0 : mx + 1;
            drv_ny = (mx == 799) ? ((my == V_TOT - 1) ? 0 : my + 1) : my;
            drv_e.cx      = 11'(drv_nx);
            drv_e.cy      = 10'(drv_ny);
            drv_e.fs      = (mx == 0) && (my == 0);
            drv_e.blank_n = drv_act;
            drv_e.hs      = !(drv_d.valid && drv_d.x >= 656 && drv_d.x <= 751);
            drv_e.vs      = !(drv_d.valid && drv_d.y >= 6 && drv_d.y <= 7);
            drv_e.rgb     = drv_act ? drv_pix : 24'h0;
            sb_q.push_back(drv_e);
            mx = drv_nx;
            my = drv_ny;
        end
    end

    // Monitor: pops one expectation per clock and compares, plus a few directed
    // interval measurements taken from the pins during the first run.
    exp_t mon_e;
    int   mcyc = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0, prev_bl = 1'b0;
    int   x656_cyc = -1, hs_fall_cyc = 0, vs_fall_cyc = 0, fs_rise_cyc = -1;
    bit   hs_fall_seen = 0, hs_len_done = 0, vs_fall_seen = 0, vs_len_done = 0;
    bit   fs_width_done = 0, fs_period_done = 0, first_pix_done = 0;
    initial forever begin
        @(negedge clk);
        #1;
        if (running) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue, expected an entry (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("counter_x",  vga.CounterX,    mon_e.cx);
                check("counter_y",  vga.CounterY,    mon_e.cy);
                check("frame_start", vga.FrameStart, mon_e.fs);
                check("blank_n",    vga.VGA_BLANK_N, mon_e.blank_n);
                check("hs",         vga.VGA_HS,      mon_e.hs);
                check("vs",         vga.VGA_VS,      mon_e.vs);
                check("rgb",        {vga.VGA_B, vga.VGA_G, vga.VGA_R}, mon_e.rgb);
                check("sync_n",     vga.VGA_SYNC_N,  0);
            end
            if (meas_en) begin
                if (vga.CounterX == 11'd656 && x656_cyc < 0) x656_cyc = mcyc;
                if (prev_hs && !vga.VGA_HS && !hs_fall_seen) begin
                    hs_fall_seen = 1;
                    hs_fall_cyc  = mcyc;
                    check("hs_start_latency", mcyc - x656_cyc, 3);
                end
                if (!prev_hs && vga.VGA_HS && hs_fall_seen && !hs_len_done) begin
                    hs_len_done = 1;
                    check("hs_low_clocks", mcyc - hs_fall_cyc, 96);
                end
                if (prev_vs && !vga.VGA_VS && !vs_fall_seen) begin
                    vs_fall_seen = 1;
                    vs_fall_cyc  = mcyc;
                    check("vs_start_cycle", mcyc, 6 * 800 + 3);
                end
                if (!prev_vs && vga.VGA_VS && vs_fall_seen && !vs_len_done) begin
                    vs_len_done = 1;
                    check("vs_low_clocks", mcyc - vs_fall_cyc, 1600);
                end
                if (!prev_fs && vga.FrameStart) begin
                    if (fs_rise_cyc >= 0 && !fs_period_done) begin
                        fs_period_done = 1;
                        check("frame_period", mcyc - fs_rise_cyc, 8000);
                    end
                    fs_rise_cyc = mcyc;
                end
                if (prev_fs && !vga.FrameStart && !fs_width_done) begin
                    fs_width_done = 1;
                    check("frame_start_width", mcyc - fs_rise_cyc, 1);
                end
                if (!prev_bl && vga.VGA_BLANK_N && !first_pix_done) begin
                    first_pix_done = 1;
                    check("first_pixel_cycle", mcyc, 3);
                    check("first_pixel_b", vga.VGA_B, 8'h00);
                end
                prev_hs = vga.VGA_HS;
                prev_vs = vga.VGA_VS;
                prev_fs = vga.FrameStart;
                prev_bl = vga.VGA_BLANK_N;
            end
            mcyc++;
        end
    end

    initial begin
        vga.PixBus = '0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_reset_pins("reset_hold");

        @(posedge clk);
        #1;
        model_restart();
        rst_n   = 1'b1;
        running = 1'b1;

        // Frame 0 with the position pattern, frame 1 with constant white.
        repeat (8001) @(negedge clk);
        #3;
        mode = 1;

        // Stop at counter (300,2) of frame 2, i.e. cycle 17900 after release.
        repeat (17900 - 8000) @(negedge clk);
        #3;
        running = 1'b0;
        meas_en = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_reset_pins("midrst_async");
        repeat (3) @(posedge clk);
        #1;
        check_reset_pins("midrst_hold");

        model_restart();
        mode    = 0;
        rst_n   = 1'b1;
        running = 1'b1;
        repeat (1000) @(negedge clk);
        #3;
        running = 1'b0;

        check("measurements_done",
              {hs_len_done, vs_len_done, fs_period_done, fs_width_done, first_pix_done}, 5'h1F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Front end of the VGA display path.
- Generates the raster counters (CounterX/CounterY) consumed by the pixel controller.
- Takes the controller's 24-bit {B G R} pixel bus back, aligns it with delayed sync/blank, and drives the board DAC pins.
- Sits between the VGA clock source and the pixel controller/DAC.

Parameters:
- CNTR_WIDTH_H, 11, width of CounterX
- CNTR_WIDTH_V, 10, width of CounterY
- R_WIDTH / G_WIDTH / B_WIDTH, 8 each, colour channel widths
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches / sync (lines)
- SYNC_POL, 0, active level of HS/VS (0 = negative)
- PIX_LATENCY, 2, clocks from counter value to valid PixBus (ROM read plus text path)

Ports:
- CLOCK  input  1  VGA pixel clock
- RESET_N  input  1  asynchronous, active-low reset
- PixBus  input  R+G+B  {B G R} pixel for the counter value presented PIX_LATENCY clocks earlier
- CounterX  output  CNTR_WIDTH_H  current horizontal position
- CounterY  output  CNTR_WIDTH_V  current line
- VGA_R / VGA_G / VGA_B  output  8 each  DAC colour
- VGA_HS / VGA_VS  output  1  sync pulses
- VGA_BLANK_N  output  1  high during active video
- VGA_SYNC_N  output  1  tied 0 (no sync-on-green)
- FrameStart  output  1  one-clock pulse when CounterX=0 and CounterY=0

Behaviour:
- Timing constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525
- Reset (async assert, sync release):
  - CounterX = 0, CounterY = 0
  - HS/VS at the inactive level (~SYNC_POL)
  - BLANK_N = 0, RGB = 0, FrameStart = 0
  - All delay-pipeline stages cleared to blank/inactive-sync.
- Counters:
  - CounterX increments every clock; at H_TOTAL-1 it wraps to 0.
  - CounterY increments only on the CounterX wrap; at V_TOTAL-1 it wraps to 0 on that same wrap.
  - No other states. The counters are registered outputs.
- Raw control, combinational from the counters:
  - active = (CounterX < H_ACTIVE) && (CounterY < V_ACTIVE)
  - hs_raw asserted for CounterX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs_raw asserted for CounterY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
  - All comparisons are unsigned and at counter width.
- Alignment pipeline:
  - active, hs_raw and vs_raw pass through a PIX_LATENCY-deep shift register.
  - The delayed stage is then registered into VGA_BLANK_N / VGA_HS / VGA_VS.
  - PixBus is registered into VGA_B/G/R ({B G R} slicing) in the same clock.
  - If the delayed active is 0, RGB is forced to 0.
  - Net result: pins reflect counter value N exactly PIX_LATENCY+1 clocks after the counters show N.
  - PIX_LATENCY=0 is legal: the pipeline is bypassed and only the output register remains.
- FrameStart: registered pulse, high in the clock after the counters become (0,0). Not delayed by PIX_LATENCY.
- Reset mid-frame: all outputs return immediately to their reset values. After release, the first active pixel reaches the pins PIX_LATENCY+1 clocks later.
- Simultaneous wraps at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 on the same edge.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480@60 timing constants and derived H_TOTAL/V_TOTAL
  - the sync polarity constant
  - the pixel-bus width (R+G+B)
- One natural sub-module: vga_delay_line, a parameterised depth/width shift register with an async active-low clear. It is used for the control pipeline and is reusable by other pixel-path blocks.

Test Plan:
- Reset hold then release:
  - Counters are 0, HS=VS=1, BLANK_N=0, RGB=0 during reset.
  - After release, CounterX reaches 1 one clock later.
- Line/frame wrap:
  - CounterX reaches 799 then 0, and CounterY steps 0→1 on that edge.
  - At (799,524) both counters go to 0 and FrameStart pulses for exactly 1 clock.
  - 420000 clocks per frame.
- Sync windows:
  - HS is low for exactly 96 clocks, starting PIX_LATENCY+1 clocks after CounterX=656.
  - VS is low for exactly 2 lines, starting at CounterY=490 (plus the same latency).
- Pixel alignment:
  - Drive PixBus = {CounterX[7:0] delayed PIX_LATENCY, 8'h55, 8'hAA}.
  - VGA_R = 8'hAA and VGA_G = 8'h55 on every active pixel.
  - VGA_B equals the low byte of the pixel's X.
  - First pixel of line 0 appears with BLANK_N=1.
- Blanking override: drive PixBus = 24'hFFFFFF constantly → RGB = 0 whenever BLANK_N = 0, including x=640..799 and y=480..524.
- Mid-frame reset: assert RESET_N at (300,200) for 3 clocks → outputs go to reset values asynchronously, and the frame restarts from (0,0) after release.
